ir_decode: RTL and testbench

IR_DECODE -- requirements
Module: ir_decode

---
 rtl/ir_decode_pkg.sv | 48 ++++
 rtl/ir_decode_cond_eval.sv | 37 +++
 rtl/ir_decode.sv | 86 ++++++++
 tb/tb_ir_decode.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ir_decode_pkg.sv
// Shared constants for the instruction-register decoder: widths, family codes,
// condition codes and the flag-nibble layout.
package ir_decode_pkg;

    localparam int unsigned IR_W   = 32;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned FAM_W  = 4;
    localparam int unsigned COND_W = 4;

    // Instruction families reported to the control state machine
    localparam logic [FAM_W-1:0] FAM_DP_IMMSH = 4'd0;
    localparam logic [FAM_W-1:0] FAM_DP_REGSH = 4'd1;
    localparam logic [FAM_W-1:0] FAM_DP_IMM   = 4'd2;
    localparam logic [FAM_W-1:0] FAM_MUL      = 4'd3;
    localparam logic [FAM_W-1:0] FAM_MULL     = 4'd4;
    localparam logic [FAM_W-1:0] FAM_LDST     = 4'd8;
    localparam logic [FAM_W-1:0] FAM_LDSTH    = 4'd9;
    localparam logic [FAM_W-1:0] FAM_SWP      = 4'd12;
    localparam logic [FAM_W-1:0] FAM_BR       = 4'd14;
    localparam logic [FAM_W-1:0] FAM_UNDEF    = 4'd15;

    // ARMv4 condition field encodings
    localparam logic [COND_W-1:0] CC_EQ = 4'b0000;
    localparam logic [COND_W-1:0] CC_NE = 4'b0001;
    localparam logic [COND_W-1:0] CC_CS = 4'b0010;
    localparam logic [COND_W-1:0] CC_CC = 4'b0011;
    localparam logic [COND_W-1:0] CC_MI = 4'b0100;
    localparam logic [COND_W-1:0] CC_PL = 4'b0101;
    localparam logic [COND_W-1:0] CC_VS = 4'b0110;
    localparam logic [COND_W-1:0] CC_VC = 4'b0111;
    localparam logic [COND_W-1:0] CC_HI = 4'b1000;
    localparam logic [COND_W-1:0] CC_LS = 4'b1001;
    localparam logic [COND_W-1:0] CC_GE = 4'b1010;
    localparam logic [COND_W-1:0] CC_LT = 4'b1011;
    localparam logic [COND_W-1:0] CC_GT = 4'b1100;
    localparam logic [COND_W-1:0] CC_LE = 4'b1101;
    localparam logic [COND_W-1:0] CC_AL = 4'b1110;
    localparam logic [COND_W-1:0] CC_NV = 4'b1111;

    // Flag nibble as delivered by the datapath: {N,Z,C,V}
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/ir_decode_cond_eval.sv
// Condition-field evaluator: decides whether an instruction executes given flags.
module cond_eval
    import ir_decode_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] nzcv,
    output logic              pass
);

    nzcv_t f;

    assign f = nzcv_t'(nzcv);

    // Map each condition code to its flag predicate; NV never passes
    always_comb begin
        pass = 1'b0;
        case (cond)
            CC_EQ: pass = f.z;
            CC_NE: pass = ~f.z;
            CC_CS: pass = f.c;
            CC_CC: pass = ~f.c;
            CC_MI: pass = f.n;
            CC_PL: pass = ~f.n;
            CC_VS: pass = f.v;
            CC_VC: pass = ~f.v;
            CC_HI: pass = f.c & ~f.z;
            CC_LS: pass = ~f.c | f.z;
            CC_GE: pass = (f.n == f.v);
            CC_LT: pass = (f.n != f.v);
            CC_GT: pass = ~f.z & (f.n == f.v);
            CC_LE: pass = f.z | (f.n != f.v);
            CC_AL: pass = 1'b1;
            CC_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/ir_decode.sv
// Instruction register, flag register and instruction-family decoder.
// Optional feature: define IR_DECODE_MULL_EN to decode long multiplies as
// family 4; otherwise that encoding is reported as undefined (family 15).
module ir_decode
    import ir_decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_ir,
    input  logic [IR_W-1:0]   mem_data,
    input  logic              ld_cc,
    input  logic [FLAG_W-1:0] alu_nzcv,
    output logic [IR_W-1:0]   ir,
    output logic [FLAG_W-1:0] nzcv,
    output logic [FAM_W-1:0]  family_number,
    output logic              COND,
    output logic              PL,
    output logic              A,
    output logic              IR_20,
    output logic              undef
);

    logic             ir_valid;
    logic [FAM_W-1:0] fam_dec;
    logic             cond_pass;

    // Instruction and flag registers; ir_valid marks that an instruction was fetched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir       <= '0;
            nzcv     <= '0;
            ir_valid <= 1'b0;
        end else begin
            if (ld_ir) begin
                ir       <= mem_data;
                ir_valid <= 1'b1;
            end
            if (ld_cc) begin
                nzcv <= alu_nzcv;
            end
        end
    end

    // Priority decode of the held instruction into a family code
    always_comb begin
        fam_dec = FAM_UNDEF;
        if (ir[27:22] == 6'b000000 && ir[7:4] == 4'b1001) begin
            fam_dec = FAM_MUL;
        end else if (ir[27:23] == 5'b00001 && ir[7:4] == 4'b1001) begin
`ifdef IR_DECODE_MULL_EN
            fam_dec = FAM_MULL;
`else
            fam_dec = FAM_UNDEF;
`endif
        end else if (ir[27:23] == 5'b00010 && ir[21:20] == 2'b00 && ir[11:4] == 8'b0000_1001) begin
            fam_dec = FAM_SWP;
        end else if (ir[27:25] == 3'b000 && ir[7] && ir[4] && ir[6:5] != 2'b00) begin
            fam_dec = FAM_LDSTH;
        end else if (ir[27:26] == 2'b00 && ir[25]) begin
            fam_dec = FAM_DP_IMM;
        end else if (ir[27:26] == 2'b00 && ir[4]) begin
            fam_dec = FAM_DP_REGSH;
        end else if (ir[27:26] == 2'b00) begin
            fam_dec = FAM_DP_IMMSH;
        end else if (ir[27:26] == 2'b01) begin
            fam_dec = FAM_LDST;
        end else if (ir[27:25] == 3'b101) begin
            fam_dec = FAM_BR;
        end
    end

    cond_eval u_cond_eval (
        .cond (ir[31:28]),
        .nzcv (nzcv),
        .pass (cond_pass)
    );

    // Until the first fetch the register holds no instruction, so report undefined
    assign family_number = ir_valid ? fam_dec : FAM_UNDEF;
    assign COND          = ir_valid & cond_pass;
    assign undef         = (family_number == FAM_UNDEF);
    assign PL            = ir[24];
    assign A             = ir[21];
    assign IR_20         = ir[20];

endmodule

// File: tb/tb_ir_decode.sv
// Self-checking bench for ir_decode: directed cases plus random loads checked
// against a reference model of the decode and condition rules.
module tb_ir_decode;

    logic        clk;
    logic        rst;
    logic        ld_ir;
    logic [31:0] mem_data;
    logic        ld_cc;
    logic [3:0]  alu_nzcv;
    logic [31:0] ir;
    logic [3:0]  nzcv;
    logic [3:0]  family_number;
    logic        COND;
    logic        PL;
    logic        A;
    logic        IR_20;
    logic        undef;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state
    logic [31:0] m_ir;
    logic [3:0]  m_nzcv;
    bit          m_valid;

    ir_decode dut (
        .clk           (clk),
        .rst           (rst),
        .ld_ir         (ld_ir),
        .mem_data      (mem_data),
        .ld_cc         (ld_cc),
        .alu_nzcv      (alu_nzcv),
        .ir            (ir),
        .nzcv          (nzcv),
        .family_number (family_number),
        .COND          (COND),
        .PL            (PL),
        .A             (A),
        .IR_20         (IR_20),
        .undef         (undef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_family(input logic [31:0] w, input bit valid);
        int op;
        op = int'(w[27:20]);
        if (!valid) return 15;
        if ((op >> 2) == 0 && w[7:4] == 4'd9) return 3;
        if ((op >> 3) == 1 && w[7:4] == 4'd9) begin
`ifdef IR_DECODE_MULL_EN
            return 4;
`else
            return 15;
`endif
        end
        if ((op >> 3) == 2 && (op % 4) == 0 && w[11:4] == 8'h09) return 12;
        if ((op >> 5) == 0 && w[7] && w[4] && w[6:5] != 2'b00) return 9;
        case (op >> 6)
            0: return w[25] ? 2 : (w[4] ? 1 : 0);
            1: return 8;
            default: return ((op >> 5) == 5) ? 14 : 15;
        endcase
    endfunction

    // Codes come in complementary pairs: base predicate for even code, inverse for odd
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f, input bit valid);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (!valid || c == 4'd15) return 1'b0;
        if (c == 4'd14) return 1'b1;
        case (int'(c) / 2)
            0: base = z;
            1: base = cy;
            2: base = n;
            3: base = v;
            4: base = cy && !z;
            5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ c[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int fam;
        fam = ref_family(m_ir, m_valid);
        chk({tag, ".ir"},     ir,                   m_ir);
        chk({tag, ".nzcv"},   32'(nzcv),            32'(m_nzcv));
        chk({tag, ".family"}, 32'(family_number),   32'(fam));
        chk({tag, ".COND"},   32'(COND),            32'(ref_cond(m_ir[31:28], m_nzcv, m_valid)));
        chk({tag, ".PL"},     32'(PL),              32'(m_ir[24]));
        chk({tag, ".A"},      32'(A),               32'(m_ir[21]));
        chk({tag, ".IR_20"},  32'(IR_20),           32'(m_ir[20]));
        chk({tag, ".undef"},  32'(undef),           32'(fam == 15));
    endtask

    task automatic step(input bit li, input logic [31:0] d, input bit lc, input logic [3:0] f);
        @(negedge clk);
        ld_ir = li; mem_data = d; ld_cc = lc; alu_nzcv = f;
        @(posedge clk);
        if (li) begin m_ir = d; m_valid = 1'b1; end
        if (lc) m_nzcv = f;
        #1;
        ld_ir = 1'b0; ld_cc = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 8))
            0: begin w[27:22] = 6'b000000; w[7:4] = 4'b1001; end
            1: begin w[27:23] = 5'b00001;  w[7:4] = 4'b1001; end
            2: begin w[27:23] = 5'b00010;  w[21:20] = 2'b00; w[11:4] = 8'h09; end
            3: begin w[27:25] = 3'b000;    w[7] = 1'b1; w[4] = 1'b1; end
            4: w[27:26] = 2'b00;
            5: w[27:26] = 2'b01;
            6: w[27:25] = 3'b101;
            7: w[27:26] = 2'b11;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst = 1'b0; ld_ir = 1'b0; mem_data = '0; ld_cc = 1'b0; alu_nzcv = '0;
        m_ir = '0; m_nzcv = '0; m_valid = 1'b0;

        // Reset state
        #12;
        chk("rst.family", 32'(family_number), 32'd15);
        chk("rst.COND",   32'(COND),          32'd0);
        chk("rst.undef",  32'(undef),         32'd1);
        chk("rst.ir",     ir,                 32'd0);
        check_all("rst");
        @(negedge clk) rst = 1'b1;

        // Flags before any fetch: still undefined, no pass
        step(1'b0, 32'hE000_0000, 1'b1, 4'b0100);
        check_all("pre_fetch_cc");

        step(1'b1, 32'hE081_0002, 1'b0, 4'b0);
        chk("add.family", 32'(family_number), 32'd0);
        chk("add.COND",   32'(COND),          32'd1);
        check_all("add");
        step(1'b1, 32'hE000_0291, 1'b0, 4'b0);
        chk("mul.family", 32'(family_number), 32'd3);
        chk("mul.A",      32'(A),             32'd0);
        check_all("mul");
        step(1'b1, 32'hE020_0291, 1'b0, 4'b0);
        chk("mla.A",      32'(A),             32'd1);
        check_all("mla");

        step(1'b1, 32'h0A00_0004, 1'b1, 4'b0000);
        chk("beq.family", 32'(family_number), 32'd14);
        chk("beq.PL",     32'(PL),            32'd0);
        chk("beq.COND",   32'(COND),          32'd0);
        check_all("beq");
        step(1'b0, 32'h0, 1'b1, 4'b0100);
        chk("beq_z.COND", 32'(COND),          32'd1);
        chk("beq_z.family", 32'(family_number), 32'd14);
        check_all("beq_z");
        step(1'b1, 32'hEB00_0000, 1'b0, 4'b0);
        chk("bl.PL",      32'(PL),            32'd1);
        check_all("bl");

        step(1'b1, 32'hE081_0392, 1'b0, 4'b0);
`ifdef IR_DECODE_MULL_EN
        chk("mull.family", 32'(family_number), 32'd4);
        chk("mull.A",      32'(A),             32'd0);
`else
        chk("mull.family", 32'(family_number), 32'd15);
        chk("mull.undef",  32'(undef),         32'd1);
`endif
        check_all("mull");

        step(1'b1, 32'hE591_2004, 1'b0, 4'b0);
        chk("ldr.family", 32'(family_number), 32'd8);
        chk("ldr.PL",     32'(PL),            32'd1);
        chk("ldr.IR_20",  32'(IR_20),         32'd1);
        check_all("ldr");
        step(1'b1, 32'hE1D1_20B4, 1'b0, 4'b0);
        chk("ldrh.family", 32'(family_number), 32'd9);
        check_all("ldrh");
        step(1'b1, 32'hE101_2092, 1'b0, 4'b0);
        chk("swp.family", 32'(family_number), 32'd12);
        check_all("swp");

        // NV condition never passes
        step(1'b1, 32'hF081_0002, 1'b0, 4'b0);
        for (int f = 0; f < 16; f++) begin
            step(1'b0, 32'h0, 1'b1, 4'(f));
            chk("nv.COND", 32'(COND), 32'd0);
        end
        // Simultaneous load: NE with Z set fails
        step(1'b1, 32'h1A00_0000, 1'b1, 4'b0100);
        chk("bne.COND", 32'(COND), 32'd0);
        check_all("bne");

        // Async reset mid-cycle, then load on the first edge after release
        @(negedge clk);
        #2 rst = 1'b0;
        m_ir = '0; m_nzcv = '0; m_valid = 1'b0;
        #1;
        chk("midrst.family", 32'(family_number), 32'd15);
        chk("midrst.ir",     ir,                 32'd0);
        check_all("midrst");
        @(negedge clk);
        rst = 1'b1; ld_ir = 1'b1; mem_data = 32'hE591_2004;
        @(posedge clk);
        m_ir = 32'hE591_2004; m_valid = 1'b1;
        #1 ld_ir = 1'b0;
        check_all("post_rst_load");

        // Random loads
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)), 4'($urandom));
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
